// File: rtl/bram_bus_slave_if.sv
// Memory-bus channel between the ray memory unit (master) and a BRAM slave.
//   ms* : request channel, master -> slave (msReady flows back)
//   sm* : response channel, slave -> master (smReady flows back)
`timescale 1ns/1ps

interface bram_bus_slave_if #(
  parameter int unsigned DATA_WIDTH      = 24,
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned MASTER_ID_WIDTH = 8
);

  logic [MASTER_ID_WIDTH-1:0] msID;
  logic [ADDRESS_WIDTH-1:0]   msAddress;
  logic [DATA_WIDTH-1:0]      msData;
  logic                       msWrite;
  logic                       msValid;
  logic                       msReady;

  logic [MASTER_ID_WIDTH-1:0] smID;
  logic [DATA_WIDTH-1:0]      smData;
  logic                       smValid;
  logic                       smReady;

  modport master (
    output msID, msAddress, msData, msWrite, msValid, smReady,
    input  msReady, smID, smData, smValid
  );

  modport slave (
    input  msID, msAddress, msData, msWrite, msValid, smReady,
    output msReady, smID, smData, smValid
  );

endinterface

// File: rtl/bram_bus_slave.sv
// BRAM-backed memory-bus slave. Accepts one read/write per cycle, returns
// read data tagged with the requester ID in request order through a
// 3-stage path and a small credit-protected response FIFO.
//
// Ports:
//   clock : single rising-edge clock
//   reset : asynchronous, active-low
//   bus   : bram_bus_slave_if.slave (ms* request channel, sm* response channel)
//
// Optional feature: define BRAM_BUS_SLAVE_WRITE_ACK_EN to make every
// accepted write return an ack beat {msID, msData} through the read path.
`timescale 1ns/1ps

module bram_bus_slave #(
  parameter int unsigned              DATA_WIDTH      = 24,
  parameter int unsigned              ADDRESS_WIDTH   = 32,
  parameter int unsigned              MASTER_ID_WIDTH = 8,
  parameter int unsigned              DEPTH_LOG2      = 12,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS    = '0,
  parameter int unsigned              FIFO_DEPTH      = 4
) (
  input  logic           clock,
  input  logic           reset,
  bram_bus_slave_if.slave bus
);

`ifdef BRAM_BUS_SLAVE_WRITE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [MASTER_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]      data;
  } beat_t;

  // Registered state
  logic                       ready_q;

  logic                       s1_valid_q;
  logic [MASTER_ID_WIDTH-1:0] s1_id_q;
  logic [DEPTH_LOG2-1:0]      s1_idx_q;
  logic                       s1_in_range_q;
  logic                       s1_write_q;
  logic [DATA_WIDTH-1:0]      s1_wdata_q;

  logic                       s2_valid_q;
  logic [MASTER_ID_WIDTH-1:0] s2_id_q;
  logic                       s2_in_range_q;
  logic                       s2_write_q;
  logic [DATA_WIDTH-1:0]      s2_wdata_q;
  logic [DATA_WIDTH-1:0]      mem_q;

  logic [DATA_WIDTH-1:0]      mem [WORDS];
  beat_t                      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;

  // Combinational
  logic [ADDRESS_WIDTH-1:0]   req_index;
  logic                       req_in_range;
  logic                       accept;
  logic                       req_write_en;
  logic                       s1_load;

  beat_t                      push_beat;
  beat_t                      head_beat;
  logic                       push;
  logic                       pop;
  logic                       fifo_nonempty;
  logic [PTR_W-1:0]           wr_ptr_n;
  logic [PTR_W-1:0]           rd_ptr_n;
  logic [CNT_W-1:0]           count_n;
  logic [1:0]                 inflight_n;
  logic                       ready_n;

  // Request decode; writes land in the BRAM the same edge they are accepted
  always_comb begin
    req_index    = bus.msAddress - BASE_ADDRESS;
    req_in_range = (req_index >> DEPTH_LOG2) == ADDRESS_WIDTH'(0);
    accept       = bus.msValid && ready_q;
    req_write_en = accept && bus.msWrite && req_in_range;
    // Only beat-producing requests enter the response pipeline
    s1_load      = accept && (!bus.msWrite || ACK_EN);
  end

  // Stage 1: registered request
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q    <= 1'b0;
      s1_id_q       <= '0;
      s1_idx_q      <= '0;
      s1_in_range_q <= 1'b0;
      s1_write_q    <= 1'b0;
      s1_wdata_q    <= '0;
    end else begin
      s1_valid_q <= s1_load;
      if (s1_load) begin
        s1_id_q       <= bus.msID;
        s1_idx_q      <= req_index[DEPTH_LOG2-1:0];
        s1_in_range_q <= req_in_range;
        s1_write_q    <= bus.msWrite;
        s1_wdata_q    <= bus.msData;
      end
    end
  end

  // Stage 2: request sideband follows the BRAM output register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid_q    <= 1'b0;
      s2_id_q       <= '0;
      s2_in_range_q <= 1'b0;
      s2_write_q    <= 1'b0;
      s2_wdata_q    <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_id_q       <= s1_id_q;
        s2_in_range_q <= s1_in_range_q;
        s2_write_q    <= s1_write_q;
        s2_wdata_q    <= s1_wdata_q;
      end
    end
  end

  // BRAM array with registered read port; contents survive reset.
  // A write and a stage-1 read on the same edge return the old word,
  // which is correct because the read was accepted first.
  always_ff @(posedge clock) begin
    if (req_write_en) begin
      mem[req_index[DEPTH_LOG2-1:0]] <= bus.msData;
    end
    mem_q <= mem[s1_idx_q];
  end

  // Beat formed at the end of stage 2
  always_comb begin
    push_beat.id   = s2_id_q;
    push_beat.data = s2_write_q    ? s2_wdata_q :
                     s2_in_range_q ? mem_q      : '0;
  end

  // FIFO and credit next-state
  always_comb begin
    fifo_nonempty = count_q != CNT_W'(0);
    push          = s2_valid_q;
    pop           = fifo_nonempty && bus.smReady;
    wr_ptr_n      = push ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_n      = pop  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_n       = count_q + CNT_W'(push) - CNT_W'(pop);
    inflight_n    = 2'(s1_load) + 2'(s1_valid_q);
    // Credit: every accepted beat-producing request has a FIFO slot reserved
    ready_n       = (SUM_W'(count_n) + SUM_W'(inflight_n)) < SUM_W'(FIFO_DEPTH);
  end

  // FIFO storage; never reset, qualified by count
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_beat;
    end
  end

  // FIFO pointers, occupancy and request-ready register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      count_q  <= count_n;
      ready_q  <= ready_n;
    end
  end

  // Response outputs: head entry, forced to zero while the FIFO is empty
  always_comb begin
    head_beat = fifo_mem[rd_ptr_q];
  end

  assign bus.msReady = ready_q;
  assign bus.smValid = fifo_nonempty;
  assign bus.smID    = fifo_nonempty ? head_beat.id   : '0;
  assign bus.smData  = fifo_nonempty ? head_beat.data : '0;

endmodule

// File: tb/tb_bram_bus_slave.sv
// Directed self-checking bench for bram_bus_slave.
`timescale 1ns/1ps

`ifdef BRAM_BUS_SLAVE_WRITE_ACK_EN
`define WR_ACK(t, i, d) expect_beat(t, i, d, ack_cyc)
`else
`define WR_ACK(t, i, d)
`endif

module tb_bram_bus_slave;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bram_bus_slave_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MASTER_ID_WIDTH(IW)) bus ();

  bram_bus_slave #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MASTER_ID_WIDTH(IW),
    .DEPTH_LOG2(12), .BASE_ADDRESS(32'h0), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } beat_t;

  beat_t       got[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned ack_cyc;

  always @(posedge clock) cyc <= cyc + 1;

  // Beat capture: a beat is consumed at the next rising edge
  always @(negedge clock) begin
    if (reset && bus.smValid && bus.smReady)
      got.push_back('{bus.smID, bus.smData, cyc});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one request and hold it until accepted; acc = cycle of acceptance
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [IW-1:0] id, output int unsigned acc);
    bit done;
    done          = 1'b0;
    acc           = 0;
    bus.msValid   = 1'b1;
    bus.msWrite   = wr;
    bus.msAddress = addr;
    bus.msData    = data;
    bus.msID      = id;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.msReady) begin
        acc  = cyc;
        done = 1'b1;
      end
      tick();
    end
    chk("issue_accepted", 64'(done), 64'd1);
    bus.msValid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [IW-1:0] id, input logic [DW-1:0] data,
                             output int unsigned bcyc);
    beat_t b;
    bcyc = 0;
    for (int i = 0; i < 60 && got.size() == 0; i++) tick();
    chk({tag, "_present"}, 64'(got.size() != 0), 64'd1);
    if (got.size() != 0) begin
      b    = got.pop_front();
      bcyc = b.cyc;
      chk({tag, "_id"}, 64'(b.id), 64'(id));
      chk({tag, "_data"}, 64'(b.data), 64'(data));
    end
  endtask

  int unsigned acc, a0, a1, b0, b1, bc;
  int          nacc, nxt;
  logic        rdy;

  initial begin
    bus.msValid   = 1'b1;
    bus.msWrite   = 1'b0;
    bus.msAddress = '0;
    bus.msData    = '0;
    bus.msID      = 8'hFF;
    bus.smReady   = 1'b1;

    // Reset held with a request pending
    repeat (3) tick();
    chk("rst_msready", 64'(bus.msReady), 64'd0);
    chk("rst_smvalid", 64'(bus.smValid), 64'd0);
    chk("rst_smid",    64'(bus.smID),    64'd0);
    chk("rst_smdata",  64'(bus.smData),  64'd0);
    bus.msValid = 1'b0;
    #2 reset = 1'b1;
    tick();
    chk("post_rst_ready", 64'(bus.msReady), 64'd1);
    repeat (5) tick();
    chk("post_rst_no_beats", 64'(got.size()), 64'd0);
    chk("post_rst_smvalid", 64'(bus.smValid), 64'd0);

    // Write then back-to-back reads
    issue(1'b1, 32'h10, 24'hABCDEF, 8'd3, acc);
    issue(1'b1, 32'h11, 24'h123456, 8'd4, acc);
    `WR_ACK("ack_w10", 8'd3, 24'hABCDEF);
    `WR_ACK("ack_w11", 8'd4, 24'h123456);
    issue(1'b0, 32'h10, 24'h0, 8'd7, a0);
    issue(1'b0, 32'h11, 24'h0, 8'd9, a1);
    chk("rd_b2b_accept", 64'(a1 - a0), 64'd1);
    expect_beat("rd10", 8'd7, 24'hABCDEF, b0);
    chk("rd10_latency", 64'(b0 - a0), 64'd3);
    expect_beat("rd11", 8'd9, 24'h123456, b1);
    chk("rd11_consecutive", 64'(b1 - b0), 64'd1);

    // Read-after-write in the next cycle sees the new word
    issue(1'b1, 32'h20, 24'h0000AA, 8'd1, acc);
    `WR_ACK("ack_w20a", 8'd1, 24'h0000AA);
    issue(1'b1, 32'h20, 24'h000055, 8'd1, acc);
    issue(1'b0, 32'h20, 24'h0, 8'd2, acc);
    `WR_ACK("ack_w20b", 8'd1, 24'h000055);
    expect_beat("raw", 8'd2, 24'h000055, bc);
    // Read followed by a write to the same word sees the older word
    issue(1'b0, 32'h20, 24'h0, 8'd6, acc);
    issue(1'b1, 32'h20, 24'h000099, 8'd1, acc);
    expect_beat("war", 8'd6, 24'h000055, bc);
    `WR_ACK("ack_w20c", 8'd1, 24'h000099);
    issue(1'b0, 32'h20, 24'h0, 8'd8, acc);
    expect_beat("war_after", 8'd8, 24'h000099, bc);

    // Backpressure: fill words 0..9, then read them with smReady low
    for (int a = 0; a < 10; a++) begin
      issue(1'b1, AW'(a), DW'(32'h100 + a), 8'd0, acc);
      `WR_ACK("ack_bp", 8'd0, DW'(32'h100 + a));
    end
    repeat (4) tick();
    bus.smReady = 1'b0;
    nacc = 0;
    nxt  = 0;
    for (int i = 0; i < 12; i++) begin
      bus.msValid   = 1'b1;
      bus.msWrite   = 1'b0;
      bus.msAddress = AW'(nxt);
      bus.msID      = IW'(32'h40 + nxt);
      rdy           = bus.msReady;
      tick();
      if (rdy) begin
        nacc++;
        nxt++;
      end
    end
    bus.msValid = 1'b0;
    chk("bp_accepted", 64'(nacc), 64'd4);
    chk("bp_ready_low", 64'(bus.msReady), 64'd0);
    chk("bp_head_valid", 64'(bus.smValid), 64'd1);
    chk("bp_head_id", 64'(bus.smID), 64'h40);
    chk("bp_head_data", 64'(bus.smData), 64'h100);
    repeat (3) tick();
    chk("bp_hold_id", 64'(bus.smID), 64'h40);
    chk("bp_hold_data", 64'(bus.smData), 64'h100);
    chk("bp_none_popped", 64'(got.size()), 64'd0);
    bus.smReady = 1'b1;
    for (int a = nxt; a < 10; a++) issue(1'b0, AW'(a), 24'h0, IW'(32'h40 + a), acc);
    for (int a = 0; a < 10; a++) expect_beat("bp", IW'(32'h40 + a), DW'(32'h100 + a), bc);
    repeat (8) tick();
    chk("bp_no_dup", 64'(got.size()), 64'd0);

    // Range boundary
    issue(1'b1, 32'd4095, 24'hFEDCBA, 8'd2, acc);
    `WR_ACK("ack_w4095", 8'd2, 24'hFEDCBA);
    issue(1'b1, 32'd0, 24'h111111, 8'd2, acc);
    `WR_ACK("ack_w0", 8'd2, 24'h111111);
    issue(1'b1, 32'd4096, 24'h222222, 8'd2, acc);
    `WR_ACK("ack_w4096", 8'd2, 24'h222222);
    issue(1'b0, 32'd4095, 24'h0, 8'h11, acc);
    issue(1'b0, 32'd4096, 24'h0, 8'h12, acc);
    issue(1'b0, 32'd0, 24'h0, 8'h13, acc);
    issue(1'b0, 32'hFFFF_FFFF, 24'h0, 8'h14, acc);
    expect_beat("rd4095", 8'h11, 24'hFEDCBA, bc);
    expect_beat("rd4096", 8'h12, 24'h000000, bc);
    expect_beat("rd0_no_alias", 8'h13, 24'h111111, bc);
    expect_beat("rd_far", 8'h14, 24'h000000, bc);

    // Reset pulse with three reads in flight
    issue(1'b0, 32'h10, 24'h0, 8'h21, acc);
    issue(1'b0, 32'h11, 24'h0, 8'h22, acc);
    issue(1'b0, 32'h20, 24'h0, 8'h23, acc);
    reset = 1'b0;
    tick();
    chk("mid_rst_smvalid_in_reset", 64'(bus.smValid), 64'd0);
    reset = 1'b1;
    repeat (6) tick();
    chk("mid_rst_no_beats", 64'(got.size()), 64'd0);
    chk("mid_rst_smvalid", 64'(bus.smValid), 64'd0);
    chk("mid_rst_ready", 64'(bus.msReady), 64'd1);
    issue(1'b0, 32'h11, 24'h0, 8'h24, a0);
    expect_beat("post_mid_rst", 8'h24, 24'h123456, b0);
    chk("post_mid_rst_latency", 64'(b0 - a0), 64'd3);

`ifdef BRAM_BUS_SLAVE_WRITE_ACK_EN
    issue(1'b1, 32'h30, 24'h777777, 8'd5, a0);
    expect_beat("wack", 8'd5, 24'h777777, b0);
    chk("wack_latency", 64'(b0 - a0), 64'd3);
`endif

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
